// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer: buffers controller writes and issues them one at a time
// to the UART transmitter, honouring its busy/CTS flow-control input.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BUSY_WAIT  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_din_8b,
  input  logic                  i_wren,
  input  logic                  i_flush,
  input  logic                  i_clr_ovf,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_drained,
  output logic [7:0]            o_dout_8b,
  output logic                  o_dout_valid,
  input  logic                  i_tx_busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned WaitW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e                state_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic [WaitW-1:0]      wait_q;
  logic [7:0]            dout_q;
  logic                  dout_valid_q;

  logic full, empty, pop, wr_accept, wr_drop;

  assign full  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (count_q == '0);

  // A flush discards everything, so it also suppresses an issue in the same cycle.
  assign pop       = (state_q == StIdle) && !empty && !i_tx_busy && !i_flush;
  assign wr_accept = i_wren && !i_flush && (!full || pop);
  assign wr_drop   = i_wren && !i_flush && full && !pop;

  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= i_din_8b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !wr_accept) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Set has priority over clear so a drop coinciding with a clear is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_q <= 1'b0;
    end else if (wr_drop) begin
      overflow_q <= 1'b1;
    end else if (i_clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            dout_q       <= mem_q[rd_ptr_q];
            dout_valid_q <= 1'b1;
            wait_q       <= '0;
            state_q      <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          // Transmitter never acknowledged with busy: assume the byte was taken.
          if (i_tx_busy) begin
            state_q <= StWaitDone;
          end else if (wait_q == WaitW'(BUSY_WAIT - 1)) begin
            state_q <= StIdle;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!i_tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_full       = full;
  assign o_empty      = empty;
  assign o_count      = count_q;
  assign o_overflow   = overflow_q;
  assign o_drained    = empty && (state_q == StIdle) && !i_tx_busy;
  assign o_dout_8b    = dout_q;
  assign o_dout_valid = dout_valid_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO and transmit sequencer between the UART controller's TX write path and the UART transmitter.
- Buffers bytes written by the controller.
- Issues them one at a time as single-cycle valid pulses to the transmitter.
- Honours the transmitter busy / flow-control input, which is tx_busy OR'd with CTS.
- Reports fill level, a sticky overflow flag and a drained-interrupt level for the controller.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2^DEPTH_LOG2 = 16 bytes)
BUSY_WAIT, 4, cycles to wait for i_tx_busy to rise after an issue before assuming the byte was taken

Ports:
i_clk  input  1  single clock for the whole block
i_rst_n  input  1  reset, asynchronous, active-low
i_din_8b  input  8  byte from controller
i_wren  input  1  write strobe, one byte per cycle
i_flush  input  1  discard all buffered bytes
i_clr_ovf  input  1  clear sticky overflow flag
o_full  output  1  count == DEPTH
o_empty  output  1  count == 0
o_count  output  DEPTH_LOG2+1  bytes currently buffered
o_overflow  output  1  sticky: a write was dropped
o_drained  output  1  level: FIFO empty AND FSM in IDLE AND i_tx_busy low
o_dout_8b  output  8  byte to transmitter (registered)
o_dout_valid  output  1  single-cycle issue pulse to transmitter
i_tx_busy  input  1  transmitter busy OR CTS deasserted

Behaviour:
Reset (async assert, sync release):
- pointers, count, o_overflow, o_dout_valid = 0; o_dout_8b = 8'h00; FSM = IDLE.
- o_empty = 1, o_full = 0, o_drained = 0 while i_tx_busy = 1, else 1.

Storage and write path:
- Circular buffer; read/write pointers DEPTH_LOG2 bits wide, wrap naturally from DEPTH-1 to 0.
- Write accepted when o_full = 0, or when a pop occurs in the same cycle.
- Write while full with no pop: byte dropped, o_overflow <= 1.
- Simultaneous accepted write and pop: count unchanged; both pointers advance.
- o_count, o_full and o_empty are derived from the registered count.

FSM states IDLE, WAIT_BUSY, WAIT_DONE:
- IDLE: if count != 0 and i_tx_busy = 0, then on that edge o_dout_8b <= mem[rd_ptr], o_dout_valid <= 1, pop (rd_ptr+1, count-1), clear wait counter, go to WAIT_BUSY. Otherwise stay.
- WAIT_BUSY: o_dout_valid <= 0.
  - i_tx_busy = 1 -> WAIT_DONE.
  - Else counter increments; when counter reaches BUSY_WAIT-1 -> IDLE (timeout, byte considered sent).
- WAIT_DONE: i_tx_busy = 0 -> IDLE.
- o_dout_valid is high for exactly one cycle per byte and never in two consecutive cycles.

Latency:
- Write strobe sampled at edge E into an empty FIFO with busy low: count = 1 after E, o_dout_valid high during the cycle after E+1.
- Back-to-back bytes: the next issue is at the earliest one cycle after busy falls (WAIT_DONE -> IDLE -> issue).

Flush:
- Next edge: pointers and count = 0; a write in the same cycle is discarded, without setting overflow.
- FSM is not reset: an in-flight byte completes its WAIT states normally.
- o_dout_valid already registered is unaffected.

Overflow clear:
- i_clr_ovf clears o_overflow.
- If a dropping write coincides with i_clr_ovf, the set wins.

o_drained is combinational from registered state plus i_tx_busy.

Test Plan:
- Reset, then write 8'hA5 once with busy low, transmitter model raises busy 1 cycle after valid for 10 cycles -> one o_dout_valid pulse with o_dout_8b = A5, at the 2nd cycle after the write edge; o_count 0->1->0; o_drained = 1 after busy falls.
- Hold i_tx_busy = 1 (CTS), write 16 bytes 00..0F, then a 17th byte 0xFF -> o_full = 1, o_count = 16, o_overflow = 1, no valid pulses. Release busy -> bytes 00..0F issued in order; 0xFF is never issued.
- Full FIFO with a write and an issue pop in the same cycle -> write accepted, o_count stays 16, o_overflow stays 0; pointer wrap verified by an issue order that continues past index 15.
- Transmitter model that never raises busy, 3 bytes queued -> each issue followed by BUSY_WAIT = 4 cycles of WAIT_BUSY; pulses spaced 5 cycles apart; data in order.
- i_flush asserted during WAIT_DONE with 5 bytes queued -> o_count = 0 next cycle; the current transfer completes; no further valid pulses; o_drained = 1 after busy falls.
- Assert i_rst_n low asynchronously mid-WAIT_BUSY with bytes queued -> outputs immediately at reset values; after release, no issue occurs until a new write arrives.
